// File: rtl/simon_game_core.sv
// Simon Says engine: LFSR-generated colour sequence, timed playback, press checking, win/lose.
// Optional input timeout is compiled in when SIMON_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module simon_game_core #(
   parameter int NUM_COLOURS    = 4,
   parameter int MAX_LEN        = 16,
   parameter int SHOW_CYCLES    = 3,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int CW            = $clog2(NUM_COLOURS),
   localparam int LW            = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   start,
   input  logic [7:0]             seed,
   input  logic [NUM_COLOURS-1:0] btn,
   output logic [NUM_COLOURS-1:0] led,
   output logic [LW-1:0]          round,
   output logic [2:0]             state_dbg,
   output logic                   game_over,
   output logic                   game_won
);

   localparam int AW    = $clog2(MAX_LEN);
   localparam int DEPTH = 1 << AW;
   localparam int TMAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TW    = $clog2(TMAX + 1);

   localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
   localparam logic [AW-1:0] GEN_LAST  = AW'(MAX_LEN - 1);
   localparam logic [LW-1:0] LEN_FULL  = LW'(MAX_LEN);

   if (!(NUM_COLOURS == 2 || NUM_COLOURS == 4 || NUM_COLOURS == 8) ||
       MAX_LEN < 2 || MAX_LEN > 32 || SHOW_CYCLES < 1 || GAP_CYCLES < 1 ||
       TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("simon_game_core: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GEN      = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_OFF = 3'd3,
      S_INPUT    = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   state_t                   state;
   logic [7:0]               lfsr;
   logic [AW-1:0]            idx;
   logic [TW-1:0]            timer;
   logic [NUM_COLOURS-1:0]   btn_prev;
   logic [CW-1:0]            mem [0:DEPTH-1];

`ifdef SIMON_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
   logic [TOW-1:0] tmo_cnt;
`endif

   function automatic logic [NUM_COLOURS-1:0] onehot(input logic [CW-1:0] c);
      logic [NUM_COLOURS-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   logic [7:0]             lfsr_next;
   logic [NUM_COLOURS-1:0] press;
   logic [NUM_COLOURS-1:0] exp_oh;
   logic [NUM_COLOURS-1:0] next_oh;
   logic [NUM_COLOURS-1:0] first_oh;
   logic                   last_in_round;

   assign lfsr_next     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign press         = btn & ~btn_prev;
   assign exp_oh        = onehot(mem[idx]);
   assign next_oh       = onehot(mem[idx + AW'(1)]);
   assign first_oh      = onehot(mem[0]);
   assign last_in_round = (LW'(idx) == round - LW'(1));
   assign state_dbg     = state;

   // NOTE: the sequence store has no reset; every entry is rewritten in GEN before it is read.
   always_ff @(posedge clk) begin
      if (state == S_GEN && !clear)
         mem[idx] <= lfsr[CW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state     <= S_IDLE;
         led       <= '0;
         round     <= '0;
         idx       <= '0;
         timer     <= '0;
         btn_prev  <= '0;
         game_over <= 1'b0;
         game_won  <= 1'b0;
         lfsr      <= 8'h00;
`ifdef SIMON_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         btn_prev <= btn;
         if (clear) begin
            state     <= S_IDLE;
            led       <= '0;
            round     <= '0;
            idx       <= '0;
            timer     <= '0;
            game_over <= 1'b0;
            game_won  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
         end else begin
            case (state)
               S_IDLE: begin
                  led <= '0;
                  if (start) begin
                     state <= S_GEN;
                     lfsr  <= (seed == 8'h00) ? 8'hA5 : seed;
                     idx   <= '0;
                  end
               end

               S_GEN: begin
                  lfsr <= lfsr_next;
                  if (idx == GEN_LAST) begin
                     state <= S_SHOW_ON;
                     round <= LW'(1);
                     idx   <= '0;
                     timer <= '0;
                     led   <= first_oh;
                  end else begin
                     idx <= idx + AW'(1);
                  end
               end

               S_SHOW_ON: begin
                  if (timer == SHOW_LAST) begin
                     state <= S_SHOW_OFF;
                     timer <= '0;
                     led   <= '0;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end

               S_SHOW_OFF: begin
                  if (timer == GAP_LAST) begin
                     timer <= '0;
                     if (last_in_round) begin
                        state <= S_INPUT;
                        idx   <= '0;
                        led   <= btn;
`ifdef SIMON_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                     end else begin
                        state <= S_SHOW_ON;
                        idx   <= idx + AW'(1);
                        led   <= next_oh;
                     end
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end

               S_INPUT: begin
                  led <= btn;
                  if (press == '0) begin
`ifdef SIMON_TIMEOUT_EN
                     if (tmo_cnt == TO_LAST) begin
                        state     <= S_LOSE;
                        led       <= '0;
                        game_over <= 1'b1;
                     end else begin
                        tmo_cnt <= tmo_cnt + TOW'(1);
                     end
`endif
                  end else if (press == exp_oh) begin
`ifdef SIMON_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                     if (!last_in_round) begin
                        idx <= idx + AW'(1);
                     end else if (round == LEN_FULL) begin
                        state     <= S_WIN;
                        led       <= '0;
                        game_over <= 1'b1;
                        game_won  <= 1'b1;
                     end else begin
                        // Round complete: replay from the first colour with one more entry.
                        state <= S_SHOW_ON;
                        round <= round + LW'(1);
                        idx   <= '0;
                        timer <= '0;
                        led   <= first_oh;
                     end
                  end else begin
                     state     <= S_LOSE;
                     led       <= '0;
                     game_over <= 1'b1;
                  end
               end

               S_WIN, S_LOSE: begin
                  led <= '0;
                  if (!start) begin
                     state     <= S_IDLE;
                     round     <= '0;
                     idx       <= '0;
                     game_over <= 1'b0;
                     game_won  <= 1'b0;
                  end
               end

               default: begin
                  state     <= S_IDLE;
                  led       <= '0;
                  round     <= '0;
                  idx       <= '0;
                  timer     <= '0;
                  game_over <= 1'b0;
                  game_won  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
